result_ascii_tx: RTL and testbench

Byte-serial ASCII transmitter for 5-bit add/subtract results: it is the output end of the console path, where the input end turns typed decimal digits and '+'/'-' into binary operands. Each accepted result (two's-complement sum plus overflow flag) is emitted as a fixed 4-byte text frame over a valid/ready byte stream. The block sits between the add/sub datapath and the console/UART byte sink.

---
 rtl/result_ascii_pkg.sv | 25 ++
 rtl/result_ascii_tx_sum_to_ascii.sv | 34 +++
 rtl/result_ascii_tx.sv | 126 ++++++++++++
 tb/tb_result_ascii_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/result_ascii_pkg.sv
// result_ascii_pkg
//   Shared definitions for the result-to-ASCII console transmitter:
//   ASCII character codes, the frame length and the transmitter state enum.
package result_ascii_pkg;

    localparam logic [7:0] PLUS  = 8'd43;
    localparam logic [7:0] MINUS = 8'd45;
    localparam logic [7:0] ZERO  = 8'd48;
    localparam logic [7:0] LF    = 8'd10;
    localparam logic [7:0] CH_E  = 8'd69;
    localparam logic [7:0] CH_R  = 8'd82;

    // Every frame is sign/tens/ones/LF or E/R/R/LF.
    localparam int FRAME_LEN = 4;

    // IDLE waits for a result; Bn presents byte n of the frame.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B0   = 3'd1,
        B1   = 3'd2,
        B2   = 3'd3,
        B3   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/result_ascii_tx_sum_to_ascii.sv
// sum_to_ascii
//   Purely combinational conversion of a 5-bit two's-complement sum
//   (-16..+15) into three ASCII characters: sign, tens digit, ones digit.
//   Zero is rendered as "+00".
// Ports:
//   sum      in  [4:0]  two's-complement value
//   sign_ch  out [7:0]  '+' for sum>=0, '-' for sum<0
//   tens_ch  out [7:0]  '0' or '1'
//   ones_ch  out [7:0]  '0'..'9'
module sum_to_ascii
    import result_ascii_pkg::*;
(
    input  logic [4:0] sum,
    output logic [7:0] sign_ch,
    output logic [7:0] tens_ch,
    output logic [7:0] ones_ch
);

    logic [5:0] ext;
    logic [5:0] mag;
    logic       ge10;
    logic [5:0] ones_val;

    // The magnitude needs 6 bits: negating -16 in 5 bits would give -16 again.
    assign ext      = {sum[4], sum};
    assign mag      = sum[4] ? (~ext + 6'd1) : ext;
    assign ge10     = (mag >= 6'd10);
    assign ones_val = ge10 ? (mag - 6'd10) : mag;

    assign sign_ch = sum[4] ? MINUS : PLUS;
    assign tens_ch = ZERO + {7'd0, ge10};
    assign ones_ch = ZERO + {2'd0, ones_val};

endmodule

// File: rtl/result_ascii_tx.sv
// result_ascii_tx
//   Output end of the console path: accepts one add/sub result at a time and
//   emits it as a 4-byte ASCII frame ("+07\n", "-16\n", "ERR\n", ...).
// Ports:
//   clk        in            rising-edge clock
//   rst        in            synchronous active-high reset
//   res_valid  in            result offered
//   res_ready  out           result can be accepted (IDLE only)
//   res_sum    in  [4:0]     two's-complement sum
//   res_ovf    in            overflow flag; frame becomes "ERR\n"
//   tx_valid   out           tx_data holds a byte (registered)
//   tx_ready   in            sink takes the byte this cycle
//   tx_data    out [7:0]     ASCII byte, 0 when tx_valid=0 (registered)
//   frame_cnt  out [CNT_W-1:0] completed frames, wraps (registered)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer keeps valid and data stable until that edge; valid
// never depends combinationally on ready. res_ready is decoded from state.
module result_ascii_tx
    import result_ascii_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [4:0]       res_sum,
    input  logic             res_ovf,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic [CNT_W-1:0] frame_cnt
);

    // Current FSM state; kept as a plain register so checkers can bind to it.
    tx_state_t  state;
    tx_state_t  state_next;

    logic [4:0] cap_sum;
    logic       cap_ovf;
    logic [4:0] cap_sum_d;
    logic       cap_ovf_d;

    logic       accept;
    logic       frame_done;
    logic [7:0] data_next;

    logic [7:0] sign_ch;
    logic [7:0] tens_ch;
    logic [7:0] ones_ch;

    assign res_ready = (state == IDLE);

    // The converter looks at the value the capture registers will hold after
    // this edge, so the B0 byte can be registered on the capture edge itself.
    // Mid-frame this is just the held capture, so input changes are ignored.
    assign cap_sum_d = accept ? res_sum : cap_sum;
    assign cap_ovf_d = accept ? res_ovf : cap_ovf;

    sum_to_ascii u_conv (
        .sum     (cap_sum_d),
        .sign_ch (sign_ch),
        .tens_ch (tens_ch),
        .ones_ch (ones_ch)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (res_valid) begin
                    accept     = 1'b1;
                    state_next = B0;
                end
            end
            B0: if (tx_ready) state_next = B1;
            B1: if (tx_ready) state_next = B2;
            B2: if (tx_ready) state_next = B3;
            B3: begin
                if (tx_ready) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte to present in the state being entered; 0 when returning to IDLE.
    always_comb begin
        data_next = 8'h00;
        unique case (state_next)
            B0:      data_next = cap_ovf_d ? CH_E : sign_ch;
            B1:      data_next = cap_ovf_d ? CH_R : tens_ch;
            B2:      data_next = cap_ovf_d ? CH_R : ones_ch;
            B3:      data_next = LF;
            default: data_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cap_sum   <= '0;
            cap_ovf   <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            frame_cnt <= '0;
        end else begin
            state    <= state_next;
            tx_valid <= (state_next != IDLE);
            tx_data  <= data_next;
            if (accept) begin
                cap_sum <= res_sum;
                cap_ovf <= res_ovf;
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_result_ascii_tx.sv
module tb_result_ascii_tx;
  import result_ascii_pkg::*;

  localparam int CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             res_valid = 1'b0;
  logic             res_ready;
  logic [4:0]       res_sum = 5'd0;
  logic             res_ovf = 1'b0;
  logic             tx_valid;
  logic             tx_ready = 1'b1;
  logic [7:0]       tx_data;
  logic [CNT_W-1:0] frame_cnt;

  result_ascii_tx #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_ovf   (res_ovf),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .frame_cnt (frame_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A busy flag and a queue of the bytes still to be sent stand in for the
  // whole transmitter; the head of the queue is what must be on tx_data.
  logic [7:0] exp_q[$];
  logic       m_busy = 1'b0;
  int         m_cnt  = 0;

  function automatic void push_frame(input logic [4:0] s, input logic o);
    int v;
    int mag;
    if (o) begin
      exp_q.push_back(8'd69); exp_q.push_back(8'd82);
      exp_q.push_back(8'd82); exp_q.push_back(8'd10);
    end else begin
      v   = $signed(s);
      mag = (v < 0) ? -v : v;
      exp_q.push_back((v < 0) ? 8'd45 : 8'd43);
      exp_q.push_back(8'(48 + mag / 10));
      exp_q.push_back(8'(48 + mag % 10));
      exp_q.push_back(8'd10);
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      if (res_valid) begin
        push_frame(res_sum, res_ovf);
        m_busy = 1'b1;
      end
    end else if (tx_ready) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        m_busy = 1'b0;
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
      end
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  bit run_cmp = 1'b0;
  always @(negedge clk) begin
    if (run_cmp) begin
      check("res_ready", res_ready, !m_busy);
      check("tx_valid", tx_valid, m_busy);
      check("tx_data", tx_data, (m_busy && exp_q.size() > 0) ? exp_q[0] : 8'h00);
      check("frame_cnt", frame_cnt, m_cnt);
    end
  end

  // Bytes actually handed over to the sink.
  logic [7:0] got_q[$];
  always @(posedge clk) begin
    if (!rst && tx_valid && tx_ready) got_q.push_back(tx_data);
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_result(input logic [4:0] s, input logic o);
    int t = 0;
    res_valid = 1'b1;
    res_sum   = s;
    res_ovf   = o;
    while (!res_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("accept timeout", 0, 1);
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!res_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("idle timeout", 0, 1);
  endtask

  task automatic run_frame(input logic [4:0] s, input logic o);
    got_q.delete();
    send_result(s, o);
    wait_idle();
  endtask

  task automatic check_bytes(input string name, input int off,
                             input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] e[4];
    e = '{b0, b1, b2, b3};
    check({name, " len"}, (got_q.size() >= off + FRAME_LEN), 1);
    if (got_q.size() >= off + FRAME_LEN) begin
      for (int i = 0; i < FRAME_LEN; i++) check(name, got_q[off + i], e[i]);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst res_ready", res_ready, 1);
    check("rst tx_valid", tx_valid, 0);
    check("rst tx_data", tx_data, 0);
    check("rst frame_cnt", frame_cnt, 0);
    run_cmp = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    // +7: latency and byte sequence, cycle by cycle
    send_result(5'b00111, 1'b0);
    check("p7 b0 valid", tx_valid, 1);
    check("p7 b0", tx_data, 43);
    @(negedge clk); check("p7 b1", tx_data, 48);
    @(negedge clk); check("p7 b2", tx_data, 55);
    @(negedge clk); check("p7 b3", tx_data, 10);
    check("p7 ready low", res_ready, 0);
    @(negedge clk);
    check("p7 ready back", res_ready, 1);
    check("p7 cnt", frame_cnt, 1);

    run_frame(5'b10000, 1'b0); check_bytes("m16", 0, 45, 49, 54, 10);
    run_frame(5'b00000, 1'b0); check_bytes("zero", 0, 43, 48, 48, 10);
    run_frame(5'b11111, 1'b0); check_bytes("m1", 0, 45, 48, 49, 10);
    run_frame(5'b01010, 1'b1); check_bytes("err", 0, 69, 82, 82, 10);
    check("err cnt", frame_cnt, 5);

    // backpressure on B1 plus a result offered mid-frame
    got_q.delete();
    send_result(5'd5, 1'b0);
    @(negedge clk);
    tx_ready  = 1'b0;
    res_valid = 1'b1;
    res_sum   = 5'b10111;
    res_ovf   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp hold data", tx_data, 48);
      check("bp hold valid", tx_valid, 1);
      check("bp not ready", res_ready, 0);
    end
    tx_ready = 1'b1;
    begin
      int t = 0;
      while (!res_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) check("bp accept timeout", 0, 1);
    end
    @(negedge clk);
    res_valid = 1'b0;
    wait_idle();
    check_bytes("bp first", 0, 43, 48, 53, 10);
    check_bytes("bp second", 4, 45, 48, 57, 10);
    check("bp cnt", frame_cnt, 7);

    // reset in the middle of a frame, with res_valid high during reset
    send_result(5'd12, 1'b0);
    @(negedge clk);
    rst       = 1'b1;
    res_valid = 1'b1;
    res_sum   = 5'd3;
    @(negedge clk);
    check("abort valid", tx_valid, 0);
    check("abort data", tx_data, 0);
    check("abort ready", res_ready, 1);
    check("abort cnt", frame_cnt, 0);
    rst       = 1'b0;
    res_valid = 1'b0;
    @(negedge clk);
    check("abort nothing captured", tx_valid, 0);
    run_frame(5'd12, 1'b0); check_bytes("after rst", 0, 43, 49, 50, 10);
    check("after rst cnt", frame_cnt, 1);

    // counter wrap
    for (int i = 0; i < 254; i++) run_frame(5'(i), (i % 7) == 0);
    check("cnt 255", frame_cnt, 255);
    run_frame(5'b01111, 1'b0); check_bytes("p15", 0, 43, 49, 53, 10);
    check("cnt wrap", frame_cnt, 0);

    repeat (2) @(negedge clk);
    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
